// File: rtl/hm_clock_pkg.sv
// Shared types and helpers for the hours:minutes clock controller.
package hm_clock_pkg;

   // Operating mode of the controller, also exported on the mode port.
   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SET_H = 2'd1,
      SET_M = 2'd2
   } mode_e;

   // Last legal BCD value of each field before it wraps back to 00.
   localparam logic [7:0] BCD_H_MAX = 8'h23;
   localparam logic [7:0] BCD_M_MAX = 8'h59;

   // Next BCD value of a two-digit field, wrapping to 00 at max.
   // The result is {tens[2:0], ones[3:0]}, the counter's load format.
   function automatic logic [6:0] bcd_inc(input logic [7:0] value,
                                          input logic [7:0] max);
      logic [6:0] r;
      if (value >= max) begin
         r = 7'h00;
      end else if (value[3:0] >= 4'd9) begin
         r = {value[6:4] + 3'd1, 4'h0};
      end else begin
         r = {value[6:4], value[3:0] + 4'd1};
      end
      return r;
   endfunction

endpackage

// File: rtl/hm_clock_ctrl_btn_repeat.sv
// Increment button front end: rising-edge detection plus hold-to-repeat.
// Emits a registered one-cycle event pulse one cycle after the triggering
// button cycle.
module btn_repeat #(
   parameter int REPEAT_DLY = 25_000_000,
   parameter int REPEAT_PER = 5_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic evt
);

   localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int CW      = $clog2(CNT_MAX + 1);

   logic          btn_q;
   logic [CW-1:0] cnt_q;
   logic          rep_q;
   logic          rise;
   logic          fire;
   logic [CW-1:0] target;

   // cnt_q counts cycles the button has been held; the first repeat waits
   // REPEAT_DLY from the press, later ones REPEAT_PER from the previous one.
   always_comb begin
      rise   = btn & ~btn_q;
      target = rep_q ? CW'(REPEAT_PER) : CW'(REPEAT_DLY);
      fire   = btn & (cnt_q == target);
   end

   // Edge register, repeat counter and the registered event pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_q <= 1'b0;
         cnt_q <= '0;
         rep_q <= 1'b0;
         evt   <= 1'b0;
      end else begin
         btn_q <= btn;
         evt   <= rise | fire;
         if (!btn) begin
            cnt_q <= '0;
            rep_q <= 1'b0;
         end else if (fire) begin
            cnt_q <= CW'(1);
            rep_q <= 1'b1;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

endmodule

// File: rtl/hm_clock_ctrl.sv
// Run/set controller for the BCD hours:minutes counter: minute prescaler,
// RUN/SET_H/SET_M mode machine, field load pulses and edit blinking.
module hm_clock_ctrl
   import hm_clock_pkg::*;
#(
   parameter int SEC_PER_MIN = 60,
   parameter int REPEAT_DLY  = 25_000_000,
   parameter int REPEAT_PER  = 5_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1s,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic [7:0] QH,
   input  logic [7:0] QM,
   output logic       ce,
   output logic       L,
   output logic       H_M,
   output logic [6:0] DI,
   output logic       blank_h,
   output logic       blank_m,
   output logic [1:0] mode,
   output logic [5:0] sec
);

   localparam logic [5:0] SEC_LAST = 6'(SEC_PER_MIN - 1);

   mode_e      mode_q, mode_d;
   logic [5:0] sec_q, sec_d;
   logic       ce_q, ce_d;
   logic       l_q, l_d;
   logic       hm_q, hm_d;
   logic [6:0] di_q, di_d;
   logic       bh_q, bh_d;
   logic       bm_q, bm_d;
   logic       mode_prev_q;
   logic       mode_evt_q;
   logic       inc_evt;

   btn_repeat #(
      .REPEAT_DLY (REPEAT_DLY),
      .REPEAT_PER (REPEAT_PER)
   ) u_btn_repeat (
      .clk (clk),
      .rst (rst),
      .btn (btn_inc),
      .evt (inc_evt)
   );

   // Mode button edge, registered so it lines up with the inc event pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_prev_q <= 1'b0;
         mode_evt_q  <= 1'b0;
      end else begin
         mode_prev_q <= btn_mode;
         mode_evt_q  <= btn_mode & ~mode_prev_q;
      end
   end

   // Next-state and next-output logic; a mode event always wins over a
   // same-cycle inc or tick, and an inc during a load pulse is dropped
   // because the counter has not yet taken the previous value.
   always_comb begin
      mode_d = mode_q;
      sec_d  = sec_q;
      ce_d   = 1'b0;
      l_d    = 1'b0;
      di_d   = di_q;
      bh_d   = bh_q;
      bm_d   = bm_q;
      case (mode_q)
         RUN: begin
            bh_d = 1'b0;
            bm_d = 1'b0;
            if (tick_1s) begin
               if (sec_q == SEC_LAST) begin
                  sec_d = 6'd0;
                  ce_d  = 1'b1;
               end else begin
                  sec_d = sec_q + 6'd1;
               end
            end
            if (mode_evt_q) begin
               mode_d = SET_H;
            end
         end
         SET_H: begin
            if (mode_evt_q) begin
               mode_d = SET_M;
               bh_d   = 1'b0;
               bm_d   = 1'b0;
            end else begin
               if (tick_1s) begin
                  bh_d = ~bh_q;
               end
               if (inc_evt && !l_q) begin
                  l_d  = 1'b1;
                  di_d = bcd_inc(QH, BCD_H_MAX);
               end
            end
         end
         SET_M: begin
            if (mode_evt_q) begin
               mode_d = RUN;
               sec_d  = 6'd0;
               bh_d   = 1'b0;
               bm_d   = 1'b0;
            end else begin
               if (tick_1s) begin
                  bm_d = ~bm_q;
               end
               if (inc_evt && !l_q) begin
                  l_d  = 1'b1;
                  di_d = bcd_inc(QM, BCD_M_MAX);
               end
            end
         end
         default: begin
            mode_d = RUN;
         end
      endcase
      hm_d = (mode_d == SET_M);
   end

   // State and output registers; every output comes straight from here.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q <= RUN;
         sec_q  <= 6'd0;
         ce_q   <= 1'b0;
         l_q    <= 1'b0;
         hm_q   <= 1'b0;
         di_q   <= 7'h00;
         bh_q   <= 1'b0;
         bm_q   <= 1'b0;
      end else begin
         mode_q <= mode_d;
         sec_q  <= sec_d;
         ce_q   <= ce_d;
         l_q    <= l_d;
         hm_q   <= hm_d;
         di_q   <= di_d;
         bh_q   <= bh_d;
         bm_q   <= bm_d;
      end
   end

   assign mode    = mode_q;
   assign sec     = sec_q;
   assign ce      = ce_q;
   assign L       = l_q;
   assign H_M     = hm_q;
   assign DI      = di_q;
   assign blank_h = bh_q;
   assign blank_m = bm_q;

endmodule

// File: doc/hm_clock_ctrl.md
# hm_clock_ctrl

Sequencing and setting controller for the BCD hours:minutes counter (`VCDHMLE`). It turns a 1 Hz strobe into the counter's one-per-minute `ce`. It runs a three-state RUN/SET_H/SET_M machine driven by two debounced buttons, and issues single-cycle `L`/`H_M`/`DI` load pulses that increment the selected field with BCD wrap. It sits between the board button/prescaler logic and the counter, and also drives display-blank flags for the field being edited.

## Interface
Parameters:
- `SEC_PER_MIN`, 60: count of `tick_1s` strobes per generated `ce`.
- `REPEAT_DLY`, 25_000_000: `clk` cycles `btn_inc` must stay high before auto-repeat starts.
- `REPEAT_PER`, 5_000_000: `clk` cycles between auto-repeat increments.

Ports (one clock `clk`; reset `rst` is synchronous, active-high):
- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  synchronous active-high reset.
- `tick_1s`  in  1  one-cycle strobe, once per second.
- `btn_mode`  in  1  debounced level, mode button.
- `btn_inc`  in  1  debounced level, increment button.
- `QH`  in  8  current hours {tens, ones}, BCD, from counter.
- `QM`  in  8  current minutes {tens, ones}, BCD, from counter.
- `ce`  out  1  minute-advance enable to counter.
- `L`  out  1  load strobe to counter.
- `H_M`  out  1  load select to counter: 1 = minutes, 0 = hours.
- `DI`  out  7  load value {tens[2:0], ones[3:0]}.
- `blank_h`  out  1  blank hours digits on display.
- `blank_m`  out  1  blank minutes digits on display.
- `mode`  out  2  0 = RUN, 1 = SET_H, 2 = SET_M.
- `sec`  out  6  seconds within current minute, 0..SEC_PER_MIN-1.

## Operation
- **Reset:** `mode`=RUN; `ce`, `L`, `H_M`, `DI`, `blank_h`, `blank_m`, `sec` all 0; repeat counter cleared.
- **Edge detection:** `btn_mode` and `btn_inc` are edge-detected with one register each. A mode event is a rising edge of `btn_mode`.
- **Increment events:**
  - A rising edge of `btn_inc` is an inc event.
  - While `btn_inc` stays high, one further inc event fires after `REPEAT_DLY` cycles, then one every `REPEAT_PER` cycles.
  - Releasing the button clears the repeat counter.
- **Mode sequence:** each mode event advances RUN→SET_H→SET_M→RUN.
- **RUN:**
  - Each `tick_1s` increments `sec`.
  - When `tick_1s` arrives with `sec`==SEC_PER_MIN-1: `sec`←0 and `ce`=1 for exactly one cycle.
  - Inc events are ignored.
- **SET_H / SET_M:**
  - `ce`=0 and `sec` is frozen.
  - Each inc event issues one load with `DI`=bcd_inc(field).
  - Hours: 0x23→0x00; ones==9 → tens+1, ones 0; otherwise ones+1.
  - Minutes: 0x59→0x00, with no carry into hours.
- **H_M:** `H_M`=1 in SET_M, 0 otherwise.
- **Leaving SET_M:** SET_M→RUN clears `sec` to 0, so the minute restarts at :00.
- **Blanking:** `blank_h` (SET_H) and `blank_m` (SET_M) toggle on each `tick_1s`. They are 0 in RUN and 0 on entry to each SET state.
- **Mode/inc collision:** a mode event and an inc event in the same cycle → mode wins and the inc is dropped.
- **Load lockout:** an inc event in the cycle where `L`=1 is dropped. The counter value is not yet updated in that cycle, so a load then would be computed from stale data.

## Timing
- `ce`, `L`, `H_M`, `DI`, `blank_*` are all registered outputs.
- **`ce`:** `tick_1s` in cycle N that completes a minute → `ce`=1 in cycle N+1 only.
- **Load pipeline:**
  - `btn_inc` rises in cycle N → edge visible in N+1.
  - `L`=1 with valid `DI`/`H_M` in cycle N+2, for one cycle.
  - Counter captures at the end of N+2; new `QH`/`QM` is visible in N+3.
- `DI` holds its last value when `L`=0.
- **`mode` latency:** `mode` updates one cycle after the mode edge is detected.
- A load already registered completes even if `mode` changes in the same cycle.
- **Tick collision:** `tick_1s` coinciding with SET→RUN exit is not counted (`sec`=0 after exit).
- **`rst` mid-load:** `rst` asserted in any cycle forces all outputs to their reset values the next cycle. No `L` pulse is issued after reset.

## Structure
- Shared package/header `hm_clock_pkg`:
  - mode encodings RUN/SET_H/SET_M;
  - constants `BCD_H_MAX`=8'h23 and `BCD_M_MAX`=8'h59;
  - function `bcd_inc(value, max)`.
- One sub-module: `btn_repeat`, which does edge detection plus the auto-repeat counter (parameters `REPEAT_DLY`, `REPEAT_PER`) and produces the inc event pulse.
- The top level holds the mode FSM, the seconds prescaler, the load register and the blink flags.

## Test plan
- **Minute tick:** reset, `SEC_PER_MIN`=60, 120 `tick_1s` strobes in RUN → exactly 2 one-cycle `ce` pulses, `sec` back to 0; `L` never 1.
- **Hours wrap:** mode once (SET_H), `QH`=0x23, one `btn_inc` press → `L`=1, `H_M`=0, `DI`=7'h00 two cycles after the rising edge; `QH`=0x09 → `DI`=7'h10.
- **Minutes wrap:** mode twice (SET_M), `QM`=0x59, press inc → `L`=1, `H_M`=1, `DI`=7'h00. A further mode event → RUN with `sec`=0 and `ce` resuming 60 ticks later.
- **Auto-repeat:** `REPEAT_DLY`=10, `REPEAT_PER`=4, hold `btn_inc` for 30 cycles in SET_M → 1+1+4 = 6 `L` pulses, none in consecutive cycles.
- **Collision:** `btn_mode` and `btn_inc` rise in the same cycle in SET_H → `mode`→SET_M, no `L`. Separately, `tick_1s` arrives in SET_H → no `ce`, `sec` unchanged.
- **Reset mid-operation:** assert `rst` in the cycle after an inc edge in SET_H → no `L` pulse, `mode`=RUN, all outputs 0.
